// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer cursor tracker.
package accel_pkg;

    localparam int SAMPLE_W = 8;
    localparam int POS_W    = 10;
    localparam int SUM_W    = 12;

    localparam int X_MAX_DEF  = 639;
    localparam int Y_MAX_DEF  = 479;
    localparam int X_CENTRE   = X_MAX_DEF / 2;
    localparam int Y_CENTRE   = Y_MAX_DEF / 2;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        AVG   = 2'd1,
        STEP  = 2'd2
    } state_e;

endpackage

// File: rtl/accel_axis.sv
// One axis of the cursor tracker: sample accumulator, group average,
// deadband/gain stage and the clamped pixel position register.
module accel_axis
    import accel_pkg::*;
#(
    parameter int AVG_LOG2   = 2,
    parameter int DEADBAND   = 8,
    parameter int GAIN_SHIFT = 3,
    parameter int AXIS_MAX   = 639,
    parameter bit INVERT     = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sample_valid_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic                       clear_i,
    input  logic                       group_done_i,
    input  logic                       avg_en_i,
    input  logic                       update_i,
    input  logic                       center_i,
    output logic [POS_W-1:0]           pos_o
);

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam logic [POS_W-1:0]        CENTRE = POS_W'(AXIS_MAX / 2);
    localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(AXIS_MAX);
    localparam logic [SAMPLE_W:0]       DB     = (SAMPLE_W + 1)'(DEADBAND);

    // Magnitude is taken one bit wider so that -128 reads as 128.
    function automatic logic signed [SAMPLE_W-1:0] deadband_step(
        input logic signed [SAMPLE_W-1:0] a
    );
        logic [SAMPLE_W:0] mag;
        mag = a[SAMPLE_W-1] ? -{a[SAMPLE_W-1], a} : {1'b0, a};
        if (mag <= DB) begin
            return '0;
        end
        return a >>> GAIN_SHIFT;
    endfunction

    // Saturate the wide signed sum into the visible pixel range.
    function automatic logic [POS_W-1:0] clamp_pos(
        input logic signed [SUM_W-1:0] s
    );
        if (s[SUM_W-1]) begin
            return '0;
        end
        if (s > MAX_S) begin
            return POS_W'(AXIS_MAX);
        end
        return s[POS_W-1:0];
    endfunction

    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [ACC_W-1:0]    sum_q, sum_d;
    logic signed [ACC_W-1:0]    sample_ext;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [SAMPLE_W-1:0] avg_q, avg_d;
    logic signed [SAMPLE_W-1:0] step;
    logic signed [SUM_W-1:0]    step_ext;
    logic signed [SUM_W-1:0]    pos_sum;
    logic [POS_W-1:0]           pos_q, pos_d;

    assign sample_ext = {{AVG_LOG2{sample_i[SAMPLE_W-1]}}, sample_i};

    // Next-state for accumulator, latched group sum, average and position.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            // A sample arriving during the clear starts the next group.
            acc_d = sample_valid_i ? sample_ext : '0;
        end else if (sample_valid_i) begin
            acc_d = acc_q + sample_ext;
        end

        sum_d = group_done_i ? (acc_q + sample_ext) : sum_q;

        shifted = sum_q >>> AVG_LOG2;
        avg_d   = avg_en_i ? shifted[SAMPLE_W-1:0] : avg_q;

        step     = deadband_step(avg_q);
        step_ext = {{(SUM_W - SAMPLE_W){step[SAMPLE_W-1]}}, step};
        if (INVERT) begin
            pos_sum = $signed({2'b00, pos_q}) - step_ext;
        end else begin
            pos_sum = $signed({2'b00, pos_q}) + step_ext;
        end

        pos_d = pos_q;
        if (center_i) begin
            pos_d = CENTRE;
        end else if (update_i) begin
            pos_d = clamp_pos(pos_sum);
        end
    end

    // Axis state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            sum_q <= '0;
            avg_q <= '0;
            pos_q <= CENTRE;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
            avg_q <= avg_d;
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/accel_cursor_tracker.sv
// Turns averaged X/Y tilt samples into a clamped screen cursor position.
// Owns the sample counter, the ACCUM/AVG/STEP sequencer, recenter priority
// and the POS_VALID strobe; per-axis arithmetic lives in accel_axis.
module accel_cursor_tracker
    import accel_pkg::*;
#(
    parameter int AVG_LOG2   = 2,
    parameter int DEADBAND   = 8,
    parameter int GAIN_SHIFT = 3,
    parameter int X_MAX      = X_MAX_DEF,
    parameter int Y_MAX      = Y_MAX_DEF
) (
    input  logic                       CLK,
    input  logic                       ARST,
    input  logic                       SAMPLE_VALID,
    input  logic signed [SAMPLE_W-1:0] XDATA,
    input  logic signed [SAMPLE_W-1:0] YDATA,
    input  logic                       RECENTER,
    output logic [POS_W-1:0]           XPOS,
    output logic [POS_W-1:0]           YPOS,
    output logic                       POS_VALID
);

    state_e               state_q, state_d;
    logic [AVG_LOG2-1:0]  cnt_q, cnt_d;
    logic                 pos_valid_q, pos_valid_d;
    logic                 group_done;
    logic                 in_avg;
    logic                 in_step;
    logic                 pos_update;

    assign group_done = SAMPLE_VALID && (cnt_q == '1);
    assign in_avg     = (state_q == AVG);
    assign in_step    = (state_q == STEP);
    assign pos_update = in_step && !RECENTER;

    // Sequencer: a completed group always restarts the AVG/STEP pipeline,
    // even when it completes while STEP is still applying the previous one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pos_valid_d = in_step || RECENTER;

        if (SAMPLE_VALID) begin
            cnt_d = cnt_q + AVG_LOG2'(1);
        end

        case (state_q)
            ACCUM:   state_d = group_done ? AVG : ACCUM;
            AVG:     state_d = STEP;
            STEP:    state_d = group_done ? AVG : ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Control registers.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            pos_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pos_valid_q <= pos_valid_d;
        end
    end

    accel_axis #(
        .AVG_LOG2   (AVG_LOG2),
        .DEADBAND   (DEADBAND),
        .GAIN_SHIFT (GAIN_SHIFT),
        .AXIS_MAX   (X_MAX),
        .INVERT     (1'b0)
    ) u_axis_x (
        .clk_i          (CLK),
        .rst_i          (ARST),
        .sample_valid_i (SAMPLE_VALID),
        .sample_i       (XDATA),
        .clear_i        (in_avg),
        .group_done_i   (group_done),
        .avg_en_i       (in_avg),
        .update_i       (pos_update),
        .center_i       (RECENTER),
        .pos_o          (XPOS)
    );

    // Positive Y tilt moves the cursor up, so the Y step is subtracted.
    accel_axis #(
        .AVG_LOG2   (AVG_LOG2),
        .DEADBAND   (DEADBAND),
        .GAIN_SHIFT (GAIN_SHIFT),
        .AXIS_MAX   (Y_MAX),
        .INVERT     (1'b1)
    ) u_axis_y (
        .clk_i          (CLK),
        .rst_i          (ARST),
        .sample_valid_i (SAMPLE_VALID),
        .sample_i       (YDATA),
        .clear_i        (in_avg),
        .group_done_i   (group_done),
        .avg_en_i       (in_avg),
        .update_i       (pos_update),
        .center_i       (RECENTER),
        .pos_o          (YPOS)
    );

    assign POS_VALID = pos_valid_q;

endmodule
